// File: rtl/zebra_pkg.sv
// Shared encodings for the five-house zebra puzzle: attribute keys, permutation constants,
// solver states and the per-level rule check used by the brute-force generator.
package zebra_pkg;

  typedef enum logic [2:0] {
    NatEnglish = 3'd0, NatSpain = 3'd1, NatUkrain = 3'd2, NatNorway = 3'd3, NatJapan = 3'd4
  } nation_key;

  typedef enum logic [2:0] {
    ColRed = 3'd0, ColGreen = 3'd1, ColIvory = 3'd2, ColYellow = 3'd3, ColBlue = 3'd4
  } color_key;

  typedef enum logic [2:0] {
    PetDog = 3'd0, PetSnail = 3'd1, PetFox = 3'd2, PetHorse = 3'd3, PetZebra = 3'd4
  } pet_key;

  typedef enum logic [2:0] {
    DrkCoffee = 3'd0, DrkTea = 3'd1, DrkMilk = 3'd2, DrkJuice = 3'd3, DrkWater = 3'd4
  } drink_key;

  typedef enum logic [2:0] {
    CigOldGold = 3'd0, CigKools = 3'd1, CigChesterfield = 3'd2, CigLucky = 3'd3,
    CigParliament = 3'd4
  } cigg_key;

  // House i holds its symbol in bits [3i+2:3i]; house 0 is the most significant for ordering.
  typedef logic [14:0] perm_t;

  localparam perm_t PermIdentity = 15'o43210;
  localparam perm_t PermLast     = 15'o01234;

  localparam int unsigned NumLevels = 5;

  localparam logic [2:0] LvlNation = 3'd0;
  localparam logic [2:0] LvlColor  = 3'd1;
  localparam logic [2:0] LvlDrink  = 3'd2;
  localparam logic [2:0] LvlCigg   = 3'd3;
  localparam logic [2:0] LvlPet    = 3'd4;

  typedef logic [2:0] state_t;
  localparam state_t StIdle = 3'd0;
  localparam state_t StEval = 3'd1;
  localparam state_t StAdv  = 3'd2;
  localparam state_t StHold = 3'd3;
  localparam state_t StDone = 3'd4;

  function automatic logic [2:0] sym(input perm_t p, input logic [2:0] h);
    return p[3*h +: 3];
  endfunction

  function automatic logic [2:0] pos_of(input perm_t p, input logic [2:0] v);
    logic [2:0] pos;
    pos = 3'd0;
    for (int h = 0; h < 5; h++) begin
      if (p[3*h +: 3] == v) pos = 3'(h);
    end
    return pos;
  endfunction

  function automatic logic adjacent(input logic [2:0] a, input logic [2:0] b);
    return (a + 3'd1 == b) || (b + 3'd1 == a);
  endfunction

  // Only the rules that became decidable at this level; shallower levels already passed.
  function automatic logic level_ok(input logic [2:0] lvl, input perm_t nat, input perm_t col,
                                    input perm_t drk, input perm_t cig, input perm_t pet);
    logic       ok;
    logic [2:0] ivory_pos;
    ok        = 1'b0;
    ivory_pos = pos_of(col, ColIvory);
    case (lvl)
      LvlNation: ok = (sym(nat, 3'd0) == NatNorway);
      LvlColor:  ok = (sym(col, pos_of(nat, NatEnglish)) == ColRed) &&
                      (ivory_pos != 3'd4) &&
                      (pos_of(col, ColGreen) == ivory_pos + 3'd1) &&
                      adjacent(pos_of(nat, NatNorway), pos_of(col, ColBlue));
      LvlDrink:  ok = (sym(drk, pos_of(col, ColGreen)) == DrkCoffee) &&
                      (sym(drk, pos_of(nat, NatUkrain)) == DrkTea) &&
                      (sym(drk, 3'd2) == DrkMilk);
      LvlCigg:   ok = (sym(cig, pos_of(col, ColYellow)) == CigKools) &&
                      (sym(cig, pos_of(drk, DrkJuice)) == CigLucky) &&
                      (sym(cig, pos_of(nat, NatJapan)) == CigParliament);
      LvlPet:    ok = (sym(pet, pos_of(nat, NatSpain)) == PetDog) &&
                      (sym(pet, pos_of(cig, CigOldGold)) == PetSnail) &&
                      adjacent(pos_of(cig, CigChesterfield), pos_of(pet, PetFox)) &&
                      adjacent(pos_of(cig, CigKools), pos_of(pet, PetHorse));
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/zebra_solver_if.sv
// Start/solution stream bundle between a host and the zebra solver.
interface zebra_solver_if;
  import zebra_pkg::*;

  logic       start;
  logic       busy;
  logic       done;
  logic       sol_valid;
  logic       sol_ready;
  perm_t      sol_nation;
  perm_t      sol_color;
  perm_t      sol_pet;
  perm_t      sol_drink;
  perm_t      sol_cigg;
  logic [7:0] sol_count;

  modport master (
    output start, sol_ready,
    input  busy, done, sol_valid, sol_nation, sol_color, sol_pet, sol_drink, sol_cigg, sol_count
  );

  modport slave (
    input  start, sol_ready,
    output busy, done, sol_valid, sol_nation, sol_color, sol_pet, sol_drink, sol_cigg, sol_count
  );
endinterface

// File: rtl/perm5_next.sv
// Combinational lexicographic successor of a five-symbol permutation (house 0 most significant).
module perm5_next
  import zebra_pkg::*;
(
  input  perm_t perm_i,
  output perm_t perm_o,
  output logic  is_last_o
);

  logic [2:0] a [5];
  logic [2:0] b [5];
  logic [2:0] c [5];
  int         k;
  int         l;

  always_comb begin
    for (int i = 0; i < 5; i++) a[i] = perm_i[3*i +: 3];

    // Pivot: rightmost ascent; swap partner: rightmost larger symbol past the pivot.
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (a[i] < a[i+1]) k = i;
    end
    l = 0;
    for (int j = 0; j < 5; j++) begin
      if (j > k && a[j] > a[k]) l = j;
    end

    b    = a;
    b[k] = a[l];
    b[l] = a[k];

    c = b;
    for (int j = 0; j < 5; j++) begin
      for (int m = 0; m < 5; m++) begin
        if (j > k && m == k + 5 - j) c[j] = b[m];
      end
    end

    perm_o    = {c[4], c[3], c[2], c[1], c[0]};
    is_last_o = (perm_i == PermLast);
  end

endmodule

// File: rtl/zebra_solver.sv
// Depth-first, level-pruned enumerator of zebra puzzle grids; emits each full solution on a
// valid/ready stream and reports exhaustion with done.
module zebra_solver
  import zebra_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  zebra_solver_if.slave bus
);

  state_t                 state_q, state_d;
  logic [2:0]             lvl_q, lvl_d;
  perm_t [NumLevels-1:0]  perm_q, perm_d;
  perm_t                  sol_nation_q, sol_nation_d;
  perm_t                  sol_color_q, sol_color_d;
  perm_t                  sol_pet_q, sol_pet_d;
  perm_t                  sol_drink_q, sol_drink_d;
  perm_t                  sol_cigg_q, sol_cigg_d;
  logic [7:0]             sol_count_q, sol_count_d;

  perm_t cur_perm;
  perm_t next_perm;
  logic  cur_last;
  logic  lvl_pass;

  // Level order is nation, color, drink, cigg, pet.
  assign cur_perm = perm_q[lvl_q];
  assign lvl_pass = level_ok(lvl_q, perm_q[0], perm_q[1], perm_q[2], perm_q[3], perm_q[4]);

  perm5_next u_next (
    .perm_i   (cur_perm),
    .perm_o   (next_perm),
    .is_last_o(cur_last)
  );

  always_comb begin
    state_d      = state_q;
    lvl_d        = lvl_q;
    perm_d       = perm_q;
    sol_nation_d = sol_nation_q;
    sol_color_d  = sol_color_q;
    sol_pet_d    = sol_pet_q;
    sol_drink_d  = sol_drink_q;
    sol_cigg_d   = sol_cigg_q;
    sol_count_d  = sol_count_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          perm_d      = {NumLevels{PermIdentity}};
          lvl_d       = LvlNation;
          sol_count_d = 8'd0;
          state_d     = StEval;
        end
      end
      StEval: begin
        if (!lvl_pass) begin
          state_d = StAdv;
        end else if (lvl_q == LvlPet) begin
          sol_nation_d = perm_q[0];
          sol_color_d  = perm_q[1];
          sol_drink_d  = perm_q[2];
          sol_cigg_d   = perm_q[3];
          sol_pet_d    = perm_q[4];
          state_d      = StHold;
        end else begin
          lvl_d                  = lvl_q + 3'd1;
          perm_d[lvl_q + 3'd1]   = PermIdentity;
        end
      end
      StAdv: begin
        if (!cur_last) begin
          perm_d[lvl_q] = next_perm;
          state_d       = StEval;
        end else if (lvl_q != LvlNation) begin
          lvl_d = lvl_q - 3'd1;
        end else begin
          state_d = StDone;
        end
      end
      StHold: begin
        if (bus.sol_ready) begin
          if (sol_count_q != 8'hff) sol_count_d = sol_count_q + 8'd1;
          state_d = StAdv;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lvl_q        <= LvlNation;
      perm_q       <= '0;
      sol_nation_q <= '0;
      sol_color_q  <= '0;
      sol_pet_q    <= '0;
      sol_drink_q  <= '0;
      sol_cigg_q   <= '0;
      sol_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      lvl_q        <= lvl_d;
      perm_q       <= perm_d;
      sol_nation_q <= sol_nation_d;
      sol_color_q  <= sol_color_d;
      sol_pet_q    <= sol_pet_d;
      sol_drink_q  <= sol_drink_d;
      sol_cigg_q   <= sol_cigg_d;
      sol_count_q  <= sol_count_d;
    end
  end

  // All outputs come from registers, so sol_ready never reaches them combinationally.
  assign bus.busy       = (state_q == StEval) || (state_q == StAdv) || (state_q == StHold);
  assign bus.sol_valid  = (state_q == StHold);
  assign bus.done       = (state_q == StDone);
  assign bus.sol_nation = sol_nation_q;
  assign bus.sol_color  = sol_color_q;
  assign bus.sol_pet    = sol_pet_q;
  assign bus.sol_drink  = sol_drink_q;
  assign bus.sol_cigg   = sol_cigg_q;
  assign bus.sol_count  = sol_count_q;

endmodule

// File: tb/tb_zebra_solver.sv
// Bench for zebra_solver: an independent house-assignment search predicts the solution set,
// and directed runs with random noise check reset, backpressure, ignored starts and restarts.
module tb_zebra_solver;
  import zebra_pkg::*;

  localparam int Bound = 300000;
  localparam int NPerm = 120;

  logic clk = 1'b0;
  logic rst_n;

  zebra_solver_if bus ();

  zebra_solver dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;

  // pl[p][v] is the house holding value v in the p-th assignment.
  int    pl [NPerm][5];
  int    m_nsol;
  perm_t m_nat, m_col, m_pet, m_drk, m_cig;
  perm_t g_nat, g_col, g_pet, g_drk, g_cig;

  localparam perm_t ExpNat = 15'o41023;
  localparam perm_t ExpCol = 15'o12043;
  localparam perm_t ExpPet = 15'o40132;
  localparam perm_t ExpDrk = 15'o03214;
  localparam perm_t ExpCig = 15'o43021;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_bench();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit nextto(input int a, input int b);
    return (a - b == 1) || (b - a == 1);
  endfunction

  task automatic build_perms();
    int np;
    int d [5];
    int y;
    bit distinct;
    np = 0;
    for (int x = 0; x < 3125; x++) begin
      y = x;
      for (int v = 0; v < 5; v++) begin
        d[v] = y % 5;
        y    = y / 5;
      end
      distinct = 1'b1;
      for (int i = 0; i < 5; i++)
        for (int j = i + 1; j < 5; j++)
          if (d[i] == d[j]) distinct = 1'b0;
      if (distinct && np < NPerm) begin
        for (int v = 0; v < 5; v++) pl[np][v] = d[v];
        np++;
      end
    end
  endtask

  // Rules phrased as "same house" / "next house" relations between value locations.
  task automatic model_solve();
    int nn [5], cc [5], dd [5], ss [5], pp [5];
    m_nsol = 0;
    m_nat = '0; m_col = '0; m_pet = '0; m_drk = '0; m_cig = '0;
    for (int a = 0; a < NPerm; a++) begin
      nn = pl[a];
      if (nn[NatNorway] != 0) continue;
      for (int b = 0; b < NPerm; b++) begin
        cc = pl[b];
        if (!(nn[NatEnglish] == cc[ColRed] && cc[ColGreen] == cc[ColIvory] + 1 &&
              nextto(nn[NatNorway], cc[ColBlue]))) continue;
        for (int c = 0; c < NPerm; c++) begin
          dd = pl[c];
          if (!(dd[DrkCoffee] == cc[ColGreen] && dd[DrkTea] == nn[NatUkrain] &&
                dd[DrkMilk] == 2)) continue;
          for (int e = 0; e < NPerm; e++) begin
            ss = pl[e];
            if (!(ss[CigKools] == cc[ColYellow] && ss[CigLucky] == dd[DrkJuice] &&
                  ss[CigParliament] == nn[NatJapan])) continue;
            for (int f = 0; f < NPerm; f++) begin
              pp = pl[f];
              if (!(pp[PetDog] == nn[NatSpain] && pp[PetSnail] == ss[CigOldGold] &&
                    nextto(ss[CigChesterfield], pp[PetFox]) &&
                    nextto(ss[CigKools], pp[PetHorse]))) continue;
              m_nsol++;
              for (int v = 0; v < 5; v++) begin
                m_nat[3*nn[v] +: 3] = 3'(v);
                m_col[3*cc[v] +: 3] = 3'(v);
                m_drk[3*dd[v] +: 3] = 3'(v);
                m_cig[3*ss[v] +: 3] = 3'(v);
                m_pet[3*pp[v] +: 3] = 3'(v);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_valid"}, 32'(bus.sol_valid), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_count"}, 32'(bus.sol_count), 0);
    chk({tag, "_nat"}, 32'(bus.sol_nation), 0);
    chk({tag, "_col"}, 32'(bus.sol_color), 0);
    chk({tag, "_pet"}, 32'(bus.sol_pet), 0);
    chk({tag, "_drk"}, 32'(bus.sol_drink), 0);
    chk({tag, "_cig"}, 32'(bus.sol_cigg), 0);
  endtask

  task automatic chk_grid_model(input string tag);
    chk({tag, "_nat"}, 32'(g_nat), 32'(m_nat));
    chk({tag, "_col"}, 32'(g_col), 32'(m_col));
    chk({tag, "_pet"}, 32'(g_pet), 32'(m_pet));
    chk({tag, "_drk"}, 32'(g_drk), 32'(m_drk));
    chk({tag, "_cig"}, 32'(g_cig), 32'(m_cig));
  endtask

  task automatic launch(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    chk({tag, "_done_clr"}, 32'(bus.done), 0);
    chk({tag, "_count_clr"}, 32'(bus.sol_count), 0);
  endtask

  // Follows a launched search; bp = cycles of sol_ready=0 after each sol_valid rise.
  task automatic run_search(input int bp, input bit noisy, input bit stop_at_sol,
                            output int lat, output int total, output int beats);
    int hold;
    bit stable;
    lat = 0; total = 0; beats = 0; hold = 0;
    for (int c = 1; c <= Bound; c++) begin
      if (bus.done) begin
        total = c;
        break;
      end
      if (bus.sol_valid) begin
        if (hold == 0) begin
          beats++;
          if (beats == 1) lat = c;
          g_nat = bus.sol_nation; g_col = bus.sol_color; g_pet = bus.sol_pet;
          g_drk = bus.sol_drink;  g_cig = bus.sol_cigg;
          if (stop_at_sol) begin
            bus.sol_ready = 1'b0;
            total = c;
            break;
          end
        end else if (bp > 0) begin
          stable = (bus.sol_nation == g_nat) && (bus.sol_color == g_col) &&
                   (bus.sol_pet == g_pet) && (bus.sol_drink == g_drk) && (bus.sol_cigg == g_cig);
          chk("hold_stable", 32'(stable), 1);
          chk("hold_busy", 32'(bus.busy), 1);
          chk("hold_done", 32'(bus.done), 0);
        end
        hold++;
        bus.sol_ready = (hold > bp);
      end else begin
        hold = 0;
        bus.sol_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (noisy) bus.start = 1'b1;
      tick();
    end
    bus.start = 1'b0;
    if (total == 0) begin
      chk("search_timeout", 0, 1);
      finish_bench();
    end
  endtask

  int lat0, tot0, lat1, tot1, beats, w;

  initial begin
    build_perms();
    model_solve();

    // Reset with random inputs
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.sol_ready = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.sol_ready = 1'($urandom_range(0, 1));
      tick();
      chk("reset_busy", 32'(bus.busy), 0);
    end
    chk_reset_outputs("reset");
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();
    tick();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_valid", 32'(bus.sol_valid), 0);

    // Baseline run, sol_ready held high
    bus.sol_ready = 1'b1;
    launch("base");
    run_search(0, 1'b0, 1'b0, lat0, tot0, beats);
    chk("base_beats", 32'(beats), 32'(m_nsol));
    chk("base_done", 32'(bus.done), 1);
    chk("base_busy", 32'(bus.busy), 0);
    chk("base_count", 32'(bus.sol_count), 32'(m_nsol));
    chk("base_bounded", 32'(tot0 < (1 << 20)), 1);
    chk_grid_model("base_model");
    chk("base_nat", 32'(g_nat), 32'(ExpNat));
    chk("base_col", 32'(g_col), 32'(ExpCol));
    chk("base_pet", 32'(g_pet), 32'(ExpPet));
    chk("base_drk", 32'(g_drk), 32'(ExpDrk));
    chk("base_cig", 32'(g_cig), 32'(ExpCig));

    // Restart from DONE with 50 cycles of backpressure and start hammered every cycle
    launch("restart");
    run_search(50, 1'b1, 1'b0, lat1, tot1, beats);
    chk("restart_latency", 32'(lat1), 32'(lat0));
    chk("restart_total", 32'(tot1), 32'(tot0 + 50));
    chk("restart_beats", 32'(beats), 32'(m_nsol));
    chk("restart_done", 32'(bus.done), 1);
    chk("restart_count", 32'(bus.sol_count), 32'(m_nsol));
    chk_grid_model("restart_model");

    // Asynchronous reset part-way through the search
    bus.sol_ready = 1'b1;
    launch("pre_reset");
    w = int'($urandom_range(2, (lat0 > 8) ? unsigned'(lat0 / 2) : 2));
    repeat (w) tick();
    chk("mid_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    launch("post_reset");
    run_search(0, 1'b0, 1'b1, lat1, tot1, beats);
    chk("post_reset_latency", 32'(lat1), 32'(lat0));
    chk_grid_model("post_reset_model");

    // Hold the solution, then abandon it with reset
    repeat (3) tick();
    chk("stall_valid", 32'(bus.sol_valid), 1);
    chk("stall_count", 32'(bus.sol_count), 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("holdrst");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_reset_outputs("after_abandon");

    finish_bench();
  end

endmodule
